// File: rtl/rv_pkg.sv
// Shared decode definitions for the 5-stage RISC-V pipeline: opcodes,
// ALUOp encodings, control-bundle layout and the opcode-to-control decoder.
package rv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_RF  = 2'b10;
    localparam logic [1:0] ALUOP_IF  = 2'b11;

    // Bit positions inside the 8-bit control bundle
    localparam int CTRL_BRANCH   = 7;
    localparam int CTRL_MEMREAD  = 6;
    localparam int CTRL_MEM2REG  = 5;
    localparam int CTRL_MEMWRITE = 4;
    localparam int CTRL_ALUSRC   = 3;
    localparam int CTRL_REGWRITE = 2;

    // Field order matches the bit positions above (branch is the MSB)
    typedef struct packed {
        logic       branch;
        logic       mem_read;
        logic       mem2reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic [1:0] alu_op;
    } ctrl_t;

    // Main control decoder; unknown opcodes produce an all-zero bundle
    function automatic ctrl_t decode_ctrl(input logic [6:0] opcode);
        ctrl_t c;
        c = '0;
        case (opcode)
            OP_R: begin
                c.reg_write = 1'b1;
                c.alu_op    = ALUOP_RF;
            end
            OP_IALU: begin
                c.alu_src   = 1'b1;
                c.reg_write = 1'b1;
                c.alu_op    = ALUOP_IF;
            end
            OP_LOAD: begin
                c.alu_src   = 1'b1;
                c.mem_read  = 1'b1;
                c.mem2reg   = 1'b1;
                c.reg_write = 1'b1;
                c.alu_op    = ALUOP_ADD;
            end
            OP_STORE: begin
                c.alu_src   = 1'b1;
                c.mem_write = 1'b1;
                c.alu_op    = ALUOP_ADD;
            end
            OP_BRANCH: begin
                c.branch    = 1'b1;
                c.alu_op    = ALUOP_BR;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/rv_regfile.sv
// Architectural register file: x0 hard-wired to zero, two combinational read
// ports with write-through bypass so a WB write is visible in the same cycle.
module rv_regfile #(
    parameter  int XLEN = 32,
    parameter  int NREG = 32,
    localparam int RW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [RW-1:0]   wa,
    input  logic [XLEN-1:0] wd,
    input  logic [RW-1:0]   ra1,
    input  logic [RW-1:0]   ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2
);

    logic [XLEN-1:0] regs [NREG];

    // Clear every register on reset; otherwise commit WB writes, skipping x0
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wa != '0)) begin
            regs[wa] <= wd;
        end
    end

    // Read ports: x0 is zero, a matching WB write bypasses the array
    always_comb begin
        rd1 = regs[ra1];
        rd2 = regs[ra2];
        if (ra1 == '0) begin
            rd1 = '0;
        end else if (we && (wa == ra1)) begin
            rd1 = wd;
        end
        if (ra2 == '0) begin
            rd2 = '0;
        end else if (we && (wa == ra2)) begin
            rd2 = wd;
        end
    end

endmodule

// File: rtl/id_stage_hz.sv
// Decode stage with integrated ID/EX register: register read, immediate and
// control generation, load-use hazard detection, flush and global hold.
module id_stage_hz
    import rv_pkg::*;
#(
    parameter  int XLEN      = 32,
    parameter  int NREG      = 32,
    parameter  int CNT_W     = 16,
    parameter  int HAZARD_EN = 1,
    localparam int RW        = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ifid_valid,
    input  logic [31:0]      ifid_instr,
    input  logic [XLEN-1:0]  ifid_pc,
    input  logic             wb_we,
    input  logic [RW-1:0]    wb_rd,
    input  logic [XLEN-1:0]  wb_data,
    input  logic             flush_i,
    input  logic             hold_i,
    output logic             stall_o,
    output logic             idex_valid,
    output logic [XLEN-1:0]  idex_rs1_data,
    output logic [XLEN-1:0]  idex_rs2_data,
    output logic [XLEN-1:0]  idex_pc,
    output logic [XLEN-1:0]  idex_imm,
    output logic [31:0]      idex_instr,
    output logic [RW-1:0]    idex_rs1,
    output logic [RW-1:0]    idex_rs2,
    output logic [RW-1:0]    idex_rd,
    output logic [7:0]       idex_ctrl,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam logic             HZ_ON   = (HAZARD_EN != 0);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [31:0]     instr;
        logic [RW-1:0]   rs1;
        logic [RW-1:0]   rs2;
        logic [RW-1:0]   rd;
        ctrl_t           ctrl;
    } idex_t;

    idex_t            idex_q;
    logic [CNT_W-1:0] stall_cnt_q;

    logic [6:0]       opcode;
    logic [RW-1:0]    rs1_idx;
    logic [RW-1:0]    rs2_idx;
    logic [RW-1:0]    rd_idx;
    logic [XLEN-1:0]  rs1_val;
    logic [XLEN-1:0]  rs2_val;
    logic [XLEN-1:0]  imm;
    ctrl_t            dec_ctrl;
    logic             lu;

    assign opcode   = ifid_instr[6:0];
    assign rs1_idx  = ifid_instr[15 +: RW];
    assign rs2_idx  = ifid_instr[20 +: RW];
    assign rd_idx   = ifid_instr[7 +: RW];
    assign dec_ctrl = decode_ctrl(opcode);

    rv_regfile #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wb_we),
        .wa    (wb_rd),
        .wd    (wb_data),
        .ra1   (rs1_idx),
        .ra2   (rs2_idx),
        .rd1   (rs1_val),
        .rd2   (rs2_val)
    );

    // Sign-extended I/S/B immediates; every other opcode yields zero
    always_comb begin
        imm = '0;
        case (opcode)
            OP_IALU, OP_LOAD:
                imm = {{(XLEN-12){ifid_instr[31]}}, ifid_instr[31:20]};
            OP_STORE:
                imm = {{(XLEN-12){ifid_instr[31]}}, ifid_instr[31:25], ifid_instr[11:7]};
            OP_BRANCH:
                imm = {{(XLEN-13){ifid_instr[31]}}, ifid_instr[31], ifid_instr[7],
                       ifid_instr[30:25], ifid_instr[11:8], 1'b0};
            default:
                imm = '0;
        endcase
    end

    // Load-use detection: a load in ID/EX whose rd matches either source field
    always_comb begin
        lu = 1'b0;
        if (HZ_ON) begin
            lu = idex_q.valid && idex_q.ctrl[CTRL_MEMREAD] && (idex_q.rd != '0) &&
                 ifid_valid && ((idex_q.rd == rs1_idx) || (idex_q.rd == rs2_idx));
        end
    end

    // A flush or a hold overrides the hazard, so no stall is requested then
    assign stall_o = lu && !flush_i && !hold_i;

    // ID/EX register: reset, flush, hold, hazard/empty bubble, then normal load
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idex_q <= '0;
        end else if (flush_i) begin
            idex_q <= '0;
        end else if (hold_i) begin
            idex_q <= idex_q;
        end else if (lu || !ifid_valid) begin
            idex_q <= '0;
        end else begin
            idex_q.valid    <= 1'b1;
            idex_q.rs1_data <= rs1_val;
            idex_q.rs2_data <= rs2_val;
            idex_q.pc       <= ifid_pc;
            idex_q.imm      <= imm;
            idex_q.instr    <= ifid_instr;
            idex_q.rs1      <= rs1_idx;
            idex_q.rs2      <= rs2_idx;
            idex_q.rd       <= rd_idx;
            idex_q.ctrl     <= dec_ctrl;
        end
    end

    // Saturating count of cycles in which a load-use stall was taken
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (stall_o && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_q <= stall_cnt_q + CNT_ONE;
        end
    end

    assign idex_valid    = idex_q.valid;
    assign idex_rs1_data = idex_q.rs1_data;
    assign idex_rs2_data = idex_q.rs2_data;
    assign idex_pc       = idex_q.pc;
    assign idex_imm      = idex_q.imm;
    assign idex_instr    = idex_q.instr;
    assign idex_rs1      = idex_q.rs1;
    assign idex_rs2      = idex_q.rs2;
    assign idex_rd       = idex_q.rd;
    assign idex_ctrl     = idex_q.ctrl;
    assign stall_cnt_o   = stall_cnt_q;

endmodule

// File: tb/tb_id_stage_hz.sv
// Randomised scoreboard bench for id_stage_hz: a behavioural model predicts
// stall_o and the next ID/EX contents for each driven cycle.
module tb_id_stage_hz;

    localparam int CNT_MAX = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ifid_valid = 1'b0;
    logic [31:0] ifid_instr = '0;
    logic [31:0] ifid_pc = '0;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        flush_i = 1'b0;
    logic        hold_i = 1'b0;

    logic        stall_o, idex_valid;
    logic [31:0] idex_rs1_data, idex_rs2_data, idex_pc, idex_imm, idex_instr;
    logic [4:0]  idex_rs1, idex_rs2, idex_rd;
    logic [7:0]  idex_ctrl;
    logic [1:0]  stall_cnt_o;

    logic        nh_stall_o, nh_idex_valid;
    logic [31:0] nh_rs1_data, nh_rs2_data, nh_pc, nh_imm, nh_instr;
    logic [4:0]  nh_rs1, nh_rs2, nh_rd;
    logic [7:0]  nh_ctrl;
    logic [1:0]  nh_stall_cnt;

    int assert_cnt = 0;
    int fail_cnt = 0;

    always #5 clk = ~clk;

    id_stage_hz #(.XLEN(32), .NREG(32), .CNT_W(2), .HAZARD_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .ifid_valid(ifid_valid), .ifid_instr(ifid_instr),
        .ifid_pc(ifid_pc), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush_i(flush_i), .hold_i(hold_i), .stall_o(stall_o), .idex_valid(idex_valid),
        .idex_rs1_data(idex_rs1_data), .idex_rs2_data(idex_rs2_data), .idex_pc(idex_pc),
        .idex_imm(idex_imm), .idex_instr(idex_instr), .idex_rs1(idex_rs1),
        .idex_rs2(idex_rs2), .idex_rd(idex_rd), .idex_ctrl(idex_ctrl),
        .stall_cnt_o(stall_cnt_o)
    );

    id_stage_hz #(.XLEN(32), .NREG(32), .CNT_W(2), .HAZARD_EN(0)) dut_nh (
        .clk(clk), .rst_n(rst_n), .ifid_valid(ifid_valid), .ifid_instr(ifid_instr),
        .ifid_pc(ifid_pc), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush_i(flush_i), .hold_i(hold_i), .stall_o(nh_stall_o), .idex_valid(nh_idex_valid),
        .idex_rs1_data(nh_rs1_data), .idex_rs2_data(nh_rs2_data), .idex_pc(nh_pc),
        .idex_imm(nh_imm), .idex_instr(nh_instr), .idex_rs1(nh_rs1),
        .idex_rs2(nh_rs2), .idex_rd(nh_rd), .idex_ctrl(nh_ctrl),
        .stall_cnt_o(nh_stall_cnt)
    );

    typedef struct {
        bit          valid;
        logic [31:0] rs1d, rs2d, pc, imm, instr;
        logic [4:0]  rs1, rs2, rd;
        logic [7:0]  ctrl;
    } idex_m_t;

    typedef struct {
        bit      stall;
        idex_m_t idex;
        int      cnt;
    } exp_t;

    exp_t        sb_q[$];
    idex_m_t     m_idex;
    logic [31:0] m_regs [32];
    int          m_cnt = 0;

    // Control byte written out field by field from the decode table
    function automatic logic [7:0] ref_ctrl(input logic [6:0] op);
        bit br, mr, m2r, mw, src, rw;
        logic [1:0] aop;
        {br, mr, m2r, mw, src, rw} = '0;
        aop = 2'b00;
        case (op)
            7'b0110011: begin rw = 1; aop = 2'b10; end
            7'b0010011: begin src = 1; rw = 1; aop = 2'b11; end
            7'b0000011: begin src = 1; mr = 1; m2r = 1; rw = 1; aop = 2'b00; end
            7'b0100011: begin src = 1; mw = 1; aop = 2'b00; end
            7'b1100011: begin br = 1; aop = 2'b01; end
            default: aop = 2'b00;
        endcase
        return {br, mr, m2r, mw, src, rw, aop};
    endfunction

    // Immediate computed as a signed integer from weighted instruction fields
    function automatic logic [31:0] ref_imm(input logic [31:0] ins);
        int v;
        v = 0;
        case (ins[6:0])
            7'b0010011, 7'b0000011:
                v = int'(ins[30:20]) - (ins[31] ? 2048 : 0);
            7'b0100011:
                v = int'(ins[30:25]) * 32 + int'(ins[11:7]) - (ins[31] ? 2048 : 0);
            7'b1100011:
                v = int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2 + int'(ins[7]) * 2048
                    - (ins[31] ? 4096 : 0);
            default: v = 0;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] rs);
        if (rs == 0) return 32'd0;
        if (wb_we && wb_rd == rs) return wb_data;
        return m_regs[rs];
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        assert_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs now on the pins
    task automatic model_step();
        exp_t    e;
        idex_m_t nxt;
        logic [4:0] rs1, rs2;
        bit lu;
        rs1 = ifid_instr[19:15];
        rs2 = ifid_instr[24:20];
        lu = m_idex.valid && m_idex.ctrl[6] && m_idex.rd != 0 && ifid_valid &&
             (m_idex.rd == rs1 || m_idex.rd == rs2);
        e.stall = lu && !flush_i && !hold_i;
        nxt = '{default: 0};
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            m_cnt = 0;
        end else begin
            if (flush_i) nxt = '{default: 0};
            else if (hold_i) nxt = m_idex;
            else if (lu || !ifid_valid) nxt = '{default: 0};
            else begin
                nxt.valid = 1;
                nxt.rs1d  = ref_read(rs1);
                nxt.rs2d  = ref_read(rs2);
                nxt.pc    = ifid_pc;
                nxt.imm   = ref_imm(ifid_instr);
                nxt.instr = ifid_instr;
                nxt.rs1   = rs1;
                nxt.rs2   = rs2;
                nxt.rd    = ifid_instr[11:7];
                nxt.ctrl  = ref_ctrl(ifid_instr[6:0]);
            end
            if (wb_we && wb_rd != 0) m_regs[wb_rd] = wb_data;
            if (e.stall && m_cnt < CNT_MAX) m_cnt++;
        end
        m_idex = nxt;
        e.idex = nxt;
        e.cnt  = m_cnt;
        sb_q.push_back(e);
    endtask

    task automatic apply_stimulus(input bit rst_v, input bit val_v, input logic [31:0] ins,
                                  input logic [31:0] pc, input bit we_v, input logic [4:0] rd_v,
                                  input logic [31:0] wd_v, input bit fl_v, input bit hd_v);
        @(negedge clk);
        rst_n = rst_v; ifid_valid = val_v; ifid_instr = ins; ifid_pc = pc;
        wb_we = we_v; wb_rd = rd_v; wb_data = wd_v; flush_i = fl_v; hold_i = hd_v;
        model_step();
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pop each expected cycle, check stall before the edge and ID/EX after it
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check_output("stall_o", {31'd0, stall_o}, {31'd0, e.stall});
                check_output("nohz_stall_o", {31'd0, nh_stall_o}, 32'd0);
                @(posedge clk);
                #1;
                check_output("idex_valid", {31'd0, idex_valid}, {31'd0, e.idex.valid});
                check_output("idex_ctrl", {24'd0, idex_ctrl}, {24'd0, e.idex.ctrl});
                check_output("idex_rs1_data", idex_rs1_data, e.idex.rs1d);
                check_output("idex_rs2_data", idex_rs2_data, e.idex.rs2d);
                check_output("idex_pc", idex_pc, e.idex.pc);
                check_output("idex_imm", idex_imm, e.idex.imm);
                check_output("idex_instr", idex_instr, e.idex.instr);
                check_output("idex_rs1", {27'd0, idex_rs1}, {27'd0, e.idex.rs1});
                check_output("idex_rs2", {27'd0, idex_rs2}, {27'd0, e.idex.rs2});
                check_output("idex_rd", {27'd0, idex_rd}, {27'd0, e.idex.rd});
                check_output("stall_cnt", {30'd0, stall_cnt_o}, e.cnt);
                check_output("nohz_stall_cnt", {30'd0, nh_stall_cnt}, 32'd0);
            end
        end
    end

    localparam logic [31:0] LW   = 32'h00412383;
    localparam logic [31:0] ADDD = 32'h00138433;

    initial begin : driver
        logic [6:0] ops [6];
        logic [31:0] ins;
        int r;
        ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0000011;
        ops[3] = 7'b0100011; ops[4] = 7'b1100011; ops[5] = 7'b0110111;
        m_idex = '{default: 0};
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;

        // Reset for two edges with a live instruction presented
        apply_stimulus(0, 1, 32'h000281B3, 32'h40, 0, 0, 0, 0, 0);
        apply_stimulus(0, 1, 32'h000281B3, 32'h40, 0, 0, 0, 0, 0);

        // Same-cycle bypass of a WB write to x5
        apply_stimulus(1, 1, 32'h000281B3, 32'h100, 1, 5, 32'hDEADBEEF, 0, 0);
        after_edge();
        check_output("bypass_rs1", idex_rs1_data, 32'hDEADBEEF);
        check_output("bypass_ctrl", {24'd0, idex_ctrl}, 32'h06);
        // Writes to x0 are dropped
        apply_stimulus(1, 1, 32'h000001B3, 32'h104, 1, 0, 32'h1234, 0, 0);
        apply_stimulus(1, 1, 32'h000001B3, 32'h108, 0, 0, 0, 0, 0);
        after_edge();
        check_output("x0_reads_zero", idex_rs1_data, 32'd0);

        // Load followed by dependent add: one bubble
        apply_stimulus(1, 1, LW, 32'h200, 0, 0, 0, 0, 0);
        apply_stimulus(1, 1, ADDD, 32'h204, 0, 0, 0, 0, 0);
        after_edge();
        check_output("lu_bubble_valid", {31'd0, idex_valid}, 32'd0);
        check_output("lu_cnt_one", {30'd0, stall_cnt_o}, 32'd1);
        apply_stimulus(1, 1, ADDD, 32'h204, 0, 0, 0, 0, 0);
        after_edge();
        check_output("lu_add_rs1", {27'd0, idex_rs1}, 32'd7);

        // Flush beats the hazard
        apply_stimulus(1, 1, LW, 32'h300, 0, 0, 0, 0, 0);
        apply_stimulus(1, 1, ADDD, 32'h304, 0, 0, 0, 1, 0);
        apply_stimulus(1, 1, ADDD, 32'h308, 0, 0, 0, 0, 0);

        // Hold for three cycles with the hazard pending, then release
        apply_stimulus(1, 1, LW, 32'h400, 0, 0, 0, 0, 0);
        repeat (3) apply_stimulus(1, 1, ADDD, 32'h404, 0, 0, 0, 0, 1);
        apply_stimulus(1, 1, ADDD, 32'h404, 0, 0, 0, 0, 0);
        apply_stimulus(1, 1, ADDD, 32'h404, 0, 0, 0, 0, 0);

        // Branch and store immediates
        apply_stimulus(1, 1, 32'hFE208CE3, 32'h500, 0, 0, 0, 0, 0);
        after_edge();
        check_output("beq_imm", idex_imm, 32'hFFFFFFF8);
        check_output("beq_ctrl", {24'd0, idex_ctrl}, 32'h81);
        apply_stimulus(1, 1, 32'hFE20AE23, 32'h504, 0, 0, 0, 0, 0);
        after_edge();
        check_output("sw_imm", idex_imm, 32'hFFFFFFFC);

        // Counter saturation over five load-use pairs
        for (int k = 0; k < 5; k++) begin
            apply_stimulus(1, 1, LW, 32'h600, 0, 0, 0, 0, 0);
            apply_stimulus(1, 1, ADDD, 32'h604, 0, 0, 0, 0, 0);
            apply_stimulus(1, 1, ADDD, 32'h604, 0, 0, 0, 0, 0);
        end
        after_edge();
        check_output("cnt_saturated", {30'd0, stall_cnt_o}, 32'd3);

        // Randomised traffic with small register indices to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            ins = $urandom;
            r = $urandom_range(0, 9);
            ins[6:0]   = (r < 3) ? ops[2] : ops[$urandom_range(0, 5)];
            ins[11:7]  = 5'($urandom_range(0, 7));
            ins[19:15] = 5'($urandom_range(0, 7));
            ins[24:20] = 5'($urandom_range(0, 7));
            apply_stimulus(($urandom_range(0, 99) != 0), ($urandom_range(0, 99) < 85), ins,
                           $urandom, $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
                           ($urandom_range(0, 99) < 8), ($urandom_range(0, 99) < 10));
        end

        apply_stimulus(1, 0, 32'd0, 32'd0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check_output("scoreboard_drained", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
